// File: rtl/input_event_queue_if.sv
// Button/CPU-side signal bundle for input_event_queue.
// master = board/CPU side driving buttons and strobes, slave = the event queue.
interface input_event_queue_if #(
    parameter int unsigned NUM_BUTTONS = 5
);
    logic [NUM_BUTTONS-1:0] buttons_n;
    logic                   rd_strobe;
    logic                   overflow_clr;
    logic [7:0]             event_data;
    logic                   event_valid;
    logic                   overflow;
    logic                   irq;

    modport master (
        output buttons_n, rd_strobe, overflow_clr,
        input  event_data, event_valid, overflow, irq
    );

    modport slave (
        input  buttons_n, rd_strobe, overflow_clr,
        output event_data, event_valid, overflow, irq
    );
endinterface

// File: rtl/input_event_queue.sv
// Turns debounced active-low button levels into a show-ahead FIFO of press/release events.
// Optional autorepeat generator is enabled by defining INPUT_AUTOREPEAT_EN.
module input_event_queue #(
    parameter int unsigned NUM_BUTTONS  = 5,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000
) (
    input logic                 clk,
    input logic                 reset_n,
    input_event_queue_if.slave  bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    logic [NUM_BUTTONS-1:0] btn_q, btn_prev_q, pending_q, pending_d, pending_clr;
    logic [7:0]             prev_pad;
    logic                   edge_found;
    logic [2:0]             edge_idx;
    logic [7:0]             edge_code;
    logic                   push_req, do_write, drop, pop, empty, full;
    logic [7:0]             push_data;
    logic [AW:0]            wr_ptr_q, rd_ptr_q;
    logic                   overflow_q, overflow_d;
    logic [7:0]             mem_q [FIFO_DEPTH];

    // Padded copy so a 3-bit index never reaches past the real button count.
    always_comb begin
        prev_pad = '1;
        prev_pad[NUM_BUTTONS-1:0] = btn_prev_q;
    end

    // Descending scan: the last hit written is the lowest set index.
    always_comb begin
        edge_found = 1'b0;
        edge_idx   = 3'd0;
        for (int i = int'(NUM_BUTTONS) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                edge_found = 1'b1;
                edge_idx   = 3'(i);
            end
        end
    end

    assign edge_code   = {~prev_pad[edge_idx], 1'b0, 3'b000, edge_idx};
    assign pending_clr = edge_found ? (NUM_BUTTONS'(1) << edge_idx) : '0;
    assign pending_d   = (pending_q & ~pending_clr) | (btn_q ^ btn_prev_q);

`ifdef INPUT_AUTOREPEAT_EN
    logic [2:0]  rep_tgt_q, rep_tgt_d;
    logic [31:0] rep_timer_q, rep_timer_d;
    logic        rep_active_q, rep_active_d;
    logic        rep_req_q, rep_req_d;
    logic        rep_push;

    assign rep_push  = rep_req_q & ~edge_found;
    assign push_req  = edge_found | rep_push;
    assign push_data = edge_found ? edge_code : {2'b11, 3'b000, rep_tgt_q};

    always_comb begin
        rep_tgt_d    = rep_tgt_q;
        rep_timer_d  = rep_timer_q;
        rep_active_d = rep_active_q;
        rep_req_d    = rep_req_q;
        if (rep_push) begin
            rep_req_d = 1'b0;
        end
        if (rep_active_q) begin
            rep_timer_d = rep_timer_q - 32'd1;
            if (rep_timer_q == 32'd0) begin
                if (!prev_pad[rep_tgt_q]) begin
                    rep_req_d   = 1'b1;
                    rep_timer_d = 32'(REPEAT_RATE - 1);
                end else begin
                    rep_active_d = 1'b0;
                    rep_req_d    = 1'b0;
                end
            end
            if (prev_pad[rep_tgt_q]) begin
                rep_active_d = 1'b0;
                rep_req_d    = 1'b0;
            end
        end
        // A new press always retargets, even if that push is dropped.
        if (edge_found && edge_code[7]) begin
            rep_tgt_d    = edge_idx;
            rep_timer_d  = 32'(REPEAT_DELAY - 1);
            rep_active_d = 1'b1;
            rep_req_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_tgt_q    <= 3'd0;
            rep_timer_q  <= 32'd0;
            rep_active_q <= 1'b0;
            rep_req_q    <= 1'b0;
        end else begin
            rep_tgt_q    <= rep_tgt_d;
            rep_timer_q  <= rep_timer_d;
            rep_active_q <= rep_active_d;
            rep_req_q    <= rep_req_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
    assign push_req   = edge_found;
    assign push_data  = edge_code;
`endif

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop      = bus.rd_strobe & ~empty;
    // A same-cycle pop frees the head slot, so a full FIFO can still accept.
    assign do_write = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        overflow_d = overflow_q;
        if (bus.overflow_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q      <= '1;
            btn_prev_q <= '1;
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            btn_q      <= bus.buttons_n;
            btn_prev_q <= btn_q;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign bus.event_valid = ~empty;
    assign bus.irq         = ~empty;
    assign bus.overflow    = overflow_q;
    assign bus.event_data  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
endmodule
